stopwatch_bcd_core: RTL and testbench

//  Four-function BCD stopwatch/timer core producing the four display digits time3..time0 (XX.XX) for the
//  hex-to-7-segment decoders and display multiplexer downstream. Owns the tick prescaler, start/pause

---
 rtl/stopwatch_bcd_core.sv | 172 +++++++++++++++++
 tb/tb_stopwatch_bcd_core.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_bcd_core.sv
// stopwatch_bcd_core: four-digit BCD stopwatch/timer (XX.XX) with an on-clock
// tick prescaler, start/pause FSM, mode/preset loading and terminal detection.

// One BCD digit step: +1 or -1 when cin is set, with ripple carry/borrow out.
module stopwatch_bcd_digit (
  input  logic [3:0] d,
  input  logic       up,
  input  logic       cin,
  output logic [3:0] nxt,
  output logic       cout
);
  // cout is raised only when this digit wraps (9->0 up, 0->9 down)
  always_comb begin
    nxt  = d;
    cout = 1'b0;
    if (cin) begin
      if (up) begin
        if (d >= 4'd9) begin
          nxt  = 4'd0;
          cout = 1'b1;
        end else begin
          nxt = d + 4'd1;
        end
      end else begin
        if (d == 4'd0) begin
          nxt  = 4'd9;
          cout = 1'b1;
        end else begin
          nxt = d - 4'd1;
        end
      end
    end
  end
endmodule

module stopwatch_bcd_core #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] m,
  input  logic [3:0] load1,
  input  logic [3:0] load2,
  output logic [3:0] time3,
  output logic [3:0] time2,
  output logic [3:0] time1,
  output logic [3:0] time0,
  output logic [2:0] state,
  output logic       done
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int ND  = 4;

  if (DIV < 2) begin : g_div_chk
    $error("stopwatch_bcd_core: CLK_HZ/TICK_HZ must be >= 2");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    RUN   = 3'b001,
    PAUSE = 3'b010,
    DONE  = 3'b100
  } state_t;

  state_t               st;
  logic [ND-1:0][3:0]   dig, dig_nxt, preset;
  logic [ND:0]          cy;
  logic [PW-1:0]        presc;
  logic                 start_q, arm, start_rise, tick, dn_q, at_term;

  function automatic logic [3:0] clamp9(input logic [3:0] v);
    return (v > 4'd9) ? 4'd9 : v;
  endfunction

  // Preset value for the current (live) mode and load digits
  always_comb begin
    case (m)
      2'b00:   preset = '0;
      2'b10:   preset = {4'd9, 4'd9, 4'd9, 4'd9};
      default: preset = {clamp9(load1), clamp9(load2), 4'd0, 4'd0};
    endcase
  end

  // Digit ripple chain; a carry/borrow leaving the top digit means every digit
  // already sits at the terminal value (all 9s up, all 0s down).
  assign cy[0] = 1'b1;
  for (genvar i = 0; i < ND; i++) begin : g_dig
    stopwatch_bcd_digit u_dig (
      .d    (dig[i]),
      .up   (~dn_q),
      .cin  (cy[i]),
      .nxt  (dig_nxt[i]),
      .cout (cy[i+1])
    );
  end
  assign at_term = cy[ND];

  // arm blocks the first cycle after reset so a start held through reset
  // release is not mistaken for a fresh rising edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_q <= 1'b0;
      arm     <= 1'b0;
    end else begin
      start_q <= start;
      arm     <= 1'b1;
    end
  end

  assign start_rise = start & ~start_q & arm;
  assign tick       = (presc == PW'(DIV - 1));

  // Control FSM with prescaler, digit register and registered done flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st    <= IDLE;
      dig   <= '0;
      presc <= '0;
      dn_q  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          dig <= preset;
          if (start_rise) begin
            st    <= RUN;
            dn_q  <= m[1];
            presc <= '0;
          end
        end
        RUN: begin
          // a start edge wins over a same-cycle tick; the prescaler holds
          if (start_rise) begin
            st <= PAUSE;
          end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
              if (at_term) begin
                st   <= DONE;
                done <= 1'b1;
              end else begin
                dig <= dig_nxt;
              end
            end
          end
        end
        PAUSE: begin
          if (start_rise) st <= RUN;
        end
        DONE: begin
          if (start_rise) begin
            st   <= IDLE;
            done <= 1'b0;
          end
        end
        default: begin
          st   <= IDLE;
          done <= 1'b0;
        end
      endcase
    end
  end

  assign state = st;
  assign time3 = dig[3];
  assign time2 = dig[2];
  assign time1 = dig[1];
  assign time0 = dig[0];
endmodule

// File: tb/tb_stopwatch_bcd_core.sv
// tb_stopwatch_bcd_core: scoreboard bench. A cycle model (count kept as a plain
// integer 0..9999) pushes the expected outputs at each rising edge; a monitor
// pops and compares at each falling edge.
`timescale 1ns/1ps
module tb_stopwatch_bcd_core;
  localparam int CLK_HZ  = 1000;
  localparam int TICK_HZ = 100;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [1:0] m = 2'b00;
  logic [3:0] load1 = 4'd0, load2 = 4'd0;
  logic [3:0] time3, time2, time1, time0;
  logic [2:0] state;
  logic       done;

  stopwatch_bcd_core #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) dut (
    .clk(clk), .reset(reset), .start(start), .m(m), .load1(load1), .load2(load2),
    .time3(time3), .time2(time2), .time1(time1), .time0(time0),
    .state(state), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st;
    int val;
    bit dn;
  } exp_t;

  exp_t  exp_q[$];
  int    n_vec = 0;
  int    n_bad = 0;
  int    n_cyc = 0;
  string phase = "reset";

  // reference model state
  int m_st = S_IDLE, m_val = 0, m_pre = 0;
  bit m_sq = 0, m_arm = 0, m_dir_dn = 0, m_rise = 0;

  function automatic int preset_of(input logic [1:0] mm, input logic [3:0] a, input logic [3:0] b);
    int ta, tb;
    ta = (a > 9) ? 9 : int'(a);
    tb = (b > 9) ? 9 : int'(b);
    case (mm)
      2'b00:   return 0;
      2'b10:   return 9999;
      default: return ta * 1000 + tb * 100;
    endcase
  endfunction

  function automatic exp_t cur_exp();
    exp_t e;
    e.st  = m_st;
    e.val = m_val;
    e.dn  = (m_st == S_DONE);
    return e;
  endfunction

  task automatic model_reset();
    m_st = S_IDLE; m_val = 0; m_pre = 0; m_sq = 0; m_arm = 0; m_dir_dn = 0;
  endtask

  // cycle model: one update per rising edge
  initial forever begin
    @(posedge clk);
    n_cyc++;
    if (!reset) begin
      model_reset();
    end else begin
      m_rise = start && !m_sq && m_arm;
      m_sq   = start;
      m_arm  = 1;
      case (m_st)
        S_IDLE: begin
          m_val = preset_of(m, load1, load2);
          if (m_rise) begin m_st = S_RUN; m_dir_dn = m[1]; m_pre = 0; end
        end
        S_RUN: begin
          if (m_rise) m_st = S_PAUSE;
          else if (m_pre == DIV - 1) begin
            m_pre = 0;
            if (m_dir_dn ? (m_val == 0) : (m_val == 9999)) m_st = S_DONE;
            else m_val = m_dir_dn ? m_val - 1 : m_val + 1;
          end else m_pre++;
        end
        S_PAUSE: if (m_rise) m_st = S_RUN;
        default: if (m_rise) m_st = S_IDLE;
      endcase
    end
    exp_q.push_back(cur_exp());
  end

  // async reset: the expectation for the current cycle becomes the reset state
  initial forever begin
    @(negedge reset);
    model_reset();
    if (exp_q.size() > 0) exp_q[exp_q.size()-1] = cur_exp();
    else exp_q.push_back(cur_exp());
  end

  // monitor: compare DUT outputs against the scoreboard on every falling edge
  initial forever begin
    exp_t       e;
    logic [15:0] want, got;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e    = exp_q.pop_front();
      want = {4'(e.val / 1000), 4'((e.val / 100) % 10), 4'((e.val / 10) % 10), 4'(e.val % 10)};
      got  = {time3, time2, time1, time0};
      n_vec++;
      if (state !== 3'(e.st) || done !== e.dn || got !== want) begin
        n_bad++;
        if (n_bad <= 20)
          $display("FAIL %s cyc %0d: got state=%b done=%b time=%h%h.%h%h, want state=%b done=%b time=%h%h.%h%h",
                   phase, n_cyc, state, done, got[15:12], got[11:8], got[7:4], got[3:0],
                   3'(e.st), e.dn, want[15:12], want[11:8], want[7:4], want[3:0]);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: sim time limit reached, got no finish, want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // assert reset between clock edges, hold two cycles, release on a falling edge
  task automatic do_reset(input logic keep_start);
    @(posedge clk);
    #2;
    start = keep_start;
    reset = 1'b0;
    hold(2);
    reset = 1'b1;
  endtask

  task automatic wait_state(input int want, input int limit, input string what);
    int i;
    for (i = 0; i < limit && m_st != want; i++) @(negedge clk);
    n_vec++;
    if (m_st != want) begin
      n_bad++;
      $display("FAIL %s: got state %0d after %0d cycles, want %0d", what, m_st, limit, want);
    end
  endtask

  initial begin
    hold(3);
    reset = 1'b1;

    phase = "up_from_zero";
    m = 2'b00; hold(2);
    pulse_start();
    hold(1010);

    phase = "down_preset_borrow";
    do_reset(1'b0);
    m = 2'b11; load1 = 4'd1; load2 = 4'd0; hold(2);
    pulse_start();
    wait_state(S_DONE, 10200, "down_to_done");
    hold(30);
    pulse_start();
    hold(5);

    phase = "up_preset_terminal";
    m = 2'b01; load1 = 4'd9; load2 = 4'd9; hold(2);
    pulse_start();
    wait_state(S_DONE, 1100, "up_to_done");
    hold(25);
    pulse_start();
    hold(4);

    phase = "idle_preset_tracking";
    m = 2'b01; load1 = 4'hC; load2 = 4'd5; hold(3);
    m = 2'b10; hold(3);
    load2 = 4'hF; m = 2'b11; hold(2);
    m = 2'b01; load2 = 4'd5; hold(2);
    pulse_start();
    hold(15);

    phase = "run_ignores_inputs";
    m = 2'b10; load1 = 4'd0; load2 = 4'd3; hold(30);

    phase = "pause_on_tick";
    begin
      int i;
      for (i = 0; i < 2 * DIV && m_pre != DIV - 1; i++) @(negedge clk);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
    end
    hold(7);
    pulse_start();
    hold(30);
    pulse_start(); hold(4); pulse_start(); hold(25);

    phase = "async_reset_start_held";
    do_reset(1'b1);
    hold(6);
    start = 1'b0; hold(2);
    pulse_start();
    hold(20);

    phase = "random";
    for (int k = 0; k < 30; k++) begin
      do_reset(1'b0);
      m = 2'($urandom_range(0, 3));
      load1 = 4'($urandom_range(0, 15));
      load2 = 4'($urandom_range(0, 15));
      hold(2);
      pulse_start();
      for (int c = 0; c < 600; c++) begin
        @(negedge clk);
        if ($urandom_range(0, 39) == 0) start = ~start;
        if ($urandom_range(0, 19) == 0) begin
          m = 2'($urandom_range(0, 3));
          load1 = 4'($urandom_range(0, 15));
          load2 = 4'($urandom_range(0, 15));
        end
      end
    end

    hold(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
